mem_access_unit: RTL

//   Initiator side of the data-memory interface: accepts one load/store request at a time from the MEM stage.

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Data-memory initiator for the MEM stage: one load/store at a time, word-aligned memory bus,
// sub-word loads extracted/extended, sub-word stores done as read-modify-write.
module mem_access_unit #(
  parameter int unsigned ADDR_BYTES = 131072,
  parameter bit          RMW_EN     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Reject before any memory access so an erroring request never touches the bus.
  always_comb begin
    req_err = 1'b0;
    if (req_size_i == 2'b11) req_err = 1'b1;
    if (req_size_i == 2'b01 && req_addr_i[0]) req_err = 1'b1;
    if (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr_i >= 32'(ADDR_BYTES)) req_err = 1'b1;
    if (!RMW_EN && req_write_i && req_size_i != 2'b10) req_err = 1'b1;
  end

  always_comb begin
    byte_sel  = mem_rdata_i[{lane_q, 3'b000} +: 8];
    half_sel  = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_data = mem_rdata_i;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_data = mem_rdata_i;
    endcase
  end

  // Lane gi of the merged word takes store data only when addressed; otherwise the read word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      logic lane_hit;
      assign lane_hit = (size_q == 2'b00) ? (lane_q == 2'(gi)) : (lane_q[1] == 1'(gi >> 1));
      assign merged[8*gi +: 8] = !lane_hit       ? mem_rdata_i[8*gi +: 8] :
                                 (size_q == 2'b00) ? wdata_q[7:0] :
                                 wdata_q[8*(gi % 2) +: 8];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            write_q  <= req_write_i;
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            lane_q   <= req_addr_i[1:0];
            wdata_q  <= req_wdata_i[15:0];
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (req_write_i && req_size_i == 2'b10) begin
              state_q     <= WR;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {req_addr_i[31:2], 2'b00};
              mem_wdata_q <= req_wdata_i;
            end else begin
              state_q    <= RD;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_addr_i[31:2], 2'b00};
            end
          end
        end
        RD: begin
          mem_read_q <= 1'b0;
          if (write_q) begin
            state_q     <= WR;
            mem_write_q <= 1'b1;
            mem_wdata_q <= merged;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data;
            mem_addr_q   <= 32'h0;
          end
        end
        WR: begin
          state_q      <= RESP;
          mem_write_q  <= 1'b0;
          mem_addr_q   <= 32'h0;
          mem_wdata_q  <= 32'h0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = rst_ni && (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
